seven_seg_capture: RTL

- Receive-side counterpart of the two-digit multiplexed seven-segment driver: samples the scanned seg/com lines, decodes each digit back to a nibble, and rebuilds the displayed byte.
- Used for loopback self-test of the display path and for sniffing the display bus of another board.
- Delivers each new stable byte over a valid/ready handshake.

---
 rtl/seven_seg_capture_pkg.sv | 42 ++++
 rtl/seven_seg_capture_seg_to_nibble.sv | 37 +++
 rtl/seven_seg_capture.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_capture_pkg.sv
// Purpose : shared definitions for the seven-segment capture path (glyphs, com codes, FSM state).
// Latency : n/a (package).
// Backpr. : n/a (package).
package seven_seg_capture_pkg;

  // Lit-segment pattern, bit0=a ... bit6=g, 1 = segment lit.
  typedef logic [6:0] seg_pattern_t;

  // Hex glyphs, shared with the encode side.
  localparam seg_pattern_t GLYPH_0 = 7'h3F;
  localparam seg_pattern_t GLYPH_1 = 7'h06;
  localparam seg_pattern_t GLYPH_2 = 7'h5B;
  localparam seg_pattern_t GLYPH_3 = 7'h4F;
  localparam seg_pattern_t GLYPH_4 = 7'h66;
  localparam seg_pattern_t GLYPH_5 = 7'h6D;
  localparam seg_pattern_t GLYPH_6 = 7'h7D;
  localparam seg_pattern_t GLYPH_7 = 7'h07;
  localparam seg_pattern_t GLYPH_8 = 7'h7F;
  localparam seg_pattern_t GLYPH_9 = 7'h6F;
  localparam seg_pattern_t GLYPH_A = 7'h77;
  localparam seg_pattern_t GLYPH_B = 7'h7C;
  localparam seg_pattern_t GLYPH_C = 7'h39;
  localparam seg_pattern_t GLYPH_D = 7'h5E;
  localparam seg_pattern_t GLYPH_E = 7'h79;
  localparam seg_pattern_t GLYPH_F = 7'h71;

  // Digit select codes.
  localparam logic [1:0] COM_UPPER = 2'b01;
  localparam logic [1:0] COM_LOWER = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } cap_state_t;

  function automatic logic com_is_valid(input logic [1:0] com);
    return (com == COM_UPPER) || (com == COM_LOWER);
  endfunction

endpackage

// File: rtl/seven_seg_capture_seg_to_nibble.sv
// Purpose : decode a lit seven-segment pattern back to its hex nibble.
// Latency : combinational.
// Backpr. : none.
// Ports   : i_lit = lit pattern (g..a); o_nibble = decoded value; o_match = pattern is a hex glyph.
module seg_to_nibble
  import seven_seg_capture_pkg::*;
(
  input  seg_pattern_t i_lit,
  output logic [3:0]   o_nibble,
  output logic         o_match
);

  always_comb begin
    o_nibble = 4'h0;
    o_match  = 1'b1;
    case (i_lit)
      GLYPH_0: o_nibble = 4'h0;
      GLYPH_1: o_nibble = 4'h1;
      GLYPH_2: o_nibble = 4'h2;
      GLYPH_3: o_nibble = 4'h3;
      GLYPH_4: o_nibble = 4'h4;
      GLYPH_5: o_nibble = 4'h5;
      GLYPH_6: o_nibble = 4'h6;
      GLYPH_7: o_nibble = 4'h7;
      GLYPH_8: o_nibble = 4'h8;
      GLYPH_9: o_nibble = 4'h9;
      GLYPH_A: o_nibble = 4'hA;
      GLYPH_B: o_nibble = 4'hB;
      GLYPH_C: o_nibble = 4'hC;
      GLYPH_D: o_nibble = 4'hD;
      GLYPH_E: o_nibble = 4'hE;
      GLYPH_F: o_nibble = 4'hF;
      default: o_match  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Purpose : sniff a two-digit multiplexed seven-segment bus and rebuild the displayed byte.
// Latency : sample at 2 + SETTLE_CYCLES + 1 clk after a com edge; data_valid 1 clk after the qualifying frame.
// Backpr. : data_valid/data_ready; an unconsumed byte is overwritten by a newer one and overrun is set.
// Ports   : clk/rst (async active-high), seg_in/com_in (raw display lines), data_out/data_valid/data_ready
//           (byte handshake), overrun/pattern_err (sticky), link_lost (no com activity).
module seven_seg_capture
  import seven_seg_capture_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter int SETTLE_CYCLES  = 16,
  parameter int STABLE_FRAMES  = 3,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic [1:0] com_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       overrun,
  output logic       pattern_err,
  output logic       link_lost
);

  localparam int         TO_W        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] STABLE_N    = 4'(STABLE_FRAMES);

  // Input synchronizers
  logic [6:0] r_seg_s1, r_seg_s2;
  logic [1:0] r_com_s1, r_com_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_s1 <= '0;
      r_seg_s2 <= '0;
      r_com_s1 <= '0;
      r_com_s2 <= '0;
    end else begin
      r_seg_s1 <= seg_in;
      r_seg_s2 <= r_seg_s1;
      r_com_s1 <= com_in;
      r_com_s2 <= r_com_s1;
    end
  end

  seg_pattern_t w_lit;
  logic [1:0]   w_com;
  assign w_lit = SEG_ACTIVE_LOW ? ~r_seg_s2 : r_seg_s2;
  assign w_com = r_com_s2;

  // Sequencer
  cap_state_t  r_state, w_state_nxt;
  logic [1:0]  r_com_cur;
  logic [7:0]  r_settle_cnt;
  logic        w_com_ok, w_com_chg, w_enter_settle, w_sample;

  assign w_com_ok  = com_is_valid(w_com);
  assign w_com_chg = (w_com != r_com_cur);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_com_ok) w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (w_com_chg)                        w_state_nxt = w_com_ok ? ST_SETTLE : ST_IDLE;
        else if (r_settle_cnt == SETTLE_LAST) w_state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: w_state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (w_com_chg) w_state_nxt = w_com_ok ? ST_SETTLE : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A com change while settling counts as a fresh entry for the new digit.
  always_comb begin
    w_enter_settle = (w_state_nxt == ST_SETTLE) && ((r_state != ST_SETTLE) || w_com_chg);
    w_sample       = (r_state == ST_SAMPLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_com_cur    <= '0;
      r_settle_cnt <= '0;
    end else if (w_enter_settle) begin
      r_com_cur    <= w_com;
      r_settle_cnt <= '0;
    end else if (r_state == ST_SETTLE) begin
      r_settle_cnt <= r_settle_cnt + 8'd1;
    end
  end

  // Link timeout: restarts on every settle entry, saturates at the last count.
  logic [TO_W-1:0] r_to_cnt;
  logic            w_timeout;
  assign w_timeout = !w_enter_settle && (r_to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_to_cnt <= '0;
    else if (w_enter_settle)     r_to_cnt <= '0;
    else if (r_to_cnt != TO_LAST) r_to_cnt <= r_to_cnt + 1'b1;
  end

  // Decode and frame assembly
  logic [3:0] w_nib;
  logic       w_match;

  seg_to_nibble u_dec (
    .i_lit   (w_lit),
    .o_nibble(w_nib),
    .o_match (w_match)
  );

  logic [3:0] r_upper, r_lower;
  logic       r_up_cap, r_lo_cap;
  logic [7:0] r_prev_frame;
  logic       r_prev_vld;
  logic [3:0] r_stable_cnt;
  logic [7:0] r_data_out;
  logic       r_data_valid, r_overrun, r_pattern_err, r_link_lost;
  logic       r_force;  // next qualifying frame updates even if equal to data_out

  logic       w_is_upper, w_sample_ok, w_sample_bad, w_frame_done, w_same, w_update, w_accept;
  logic [7:0] w_frame;
  logic [3:0] w_stable_nxt;

  assign w_is_upper   = (r_com_cur == COM_UPPER);
  assign w_sample_ok  = w_sample && w_match;
  assign w_sample_bad = w_sample && !w_match;
  // The frame completes on the sample that supplies the missing digit.
  assign w_frame_done = w_sample_ok && (w_is_upper ? r_lo_cap : r_up_cap);
  assign w_frame      = w_is_upper ? {w_nib, r_lower} : {r_upper, w_nib};
  assign w_same       = r_prev_vld && (w_frame == r_prev_frame);
  assign w_stable_nxt = !w_same ? 4'd1 : ((r_stable_cnt == 4'hF) ? 4'hF : r_stable_cnt + 4'd1);
  assign w_update     = w_frame_done && !w_timeout && (w_stable_nxt >= STABLE_N) &&
                        ((w_frame != r_data_out) || r_force);
  assign w_accept     = r_data_valid && data_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_upper       <= '0;
      r_lower       <= '0;
      r_up_cap      <= 1'b0;
      r_lo_cap      <= 1'b0;
      r_prev_frame  <= '0;
      r_prev_vld    <= 1'b0;
      r_stable_cnt  <= '0;
      r_pattern_err <= 1'b0;
      r_link_lost   <= 1'b0;
      r_force       <= 1'b1;
      r_data_out    <= '0;
      r_data_valid  <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      if (w_sample_ok && w_is_upper)  r_upper <= w_nib;
      if (w_sample_ok && !w_is_upper) r_lower <= w_nib;

      if (w_timeout) begin
        r_up_cap     <= 1'b0;
        r_lo_cap     <= 1'b0;
        r_stable_cnt <= '0;
        r_prev_vld   <= 1'b0;
        r_link_lost  <= 1'b1;
        r_force      <= 1'b1;
      end else if (w_sample_bad) begin
        r_pattern_err <= 1'b1;
        r_up_cap      <= 1'b0;
        r_lo_cap      <= 1'b0;
        r_stable_cnt  <= '0;
      end else if (w_frame_done) begin
        r_up_cap     <= 1'b0;
        r_lo_cap     <= 1'b0;
        r_stable_cnt <= w_stable_nxt;
        r_prev_frame <= w_frame;
        r_prev_vld   <= 1'b1;
        r_link_lost  <= 1'b0;
      end else if (w_sample_ok) begin
        if (w_is_upper) r_up_cap <= 1'b1;
        else            r_lo_cap <= 1'b1;
      end

      // An update wins over a same-cycle accept: the new byte stays valid.
      if (w_update) begin
        r_data_out   <= w_frame;
        r_data_valid <= 1'b1;
        r_force      <= 1'b0;
        if (r_data_valid && !data_ready) r_overrun <= 1'b1;
      end else if (w_accept) begin
        r_data_valid <= 1'b0;
      end
    end
  end

  assign data_out    = r_data_out;
  assign data_valid  = r_data_valid;
  assign overrun     = r_overrun;
  assign pattern_err = r_pattern_err;
  assign link_lost   = r_link_lost;

endmodule
